multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL be the maximum memory wait cycles per access before a bus fault; legal range 2..256.
REQ-002 Parameter ENABLE_STORE, default 1, SHALL enable store decoding; 0 SHALL make OPCODE_STORE illegal.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  in  1  reset, synchronous, active-high.
REQ-005 ir_i  in  32  current instruction register contents (RV32I encoding).
REQ-006 mem_ready_i  in  1  memory completes the current request this cycle.
REQ-007 branch_taken_i  in  1  ALU branch comparison result, valid in EXEC.
REQ-008 pc_we_o  out  1  PC write enable.
REQ-009 ir_we_o  out  1  IR write enable.
REQ-010 regfile_we_o  out  1  register file write enable.
REQ-011 mem_req_o  out  1  memory request valid.
REQ-012 mem_we_o  out  1  memory request is a write (valid with mem_req_o).
REQ-013 mem_addr_sel_o  out  1  0 = PC, 1 = ALU output.
REQ-014 next_pc_sel_o  out  2  0 = PC+4, 1 = ALU output (branch/JAL/JALR target), 2/3 reserved.
REQ-015 regfile_in_sel_o  out  2  0 = ALU output, 1 = memory read data, 2 = PC+4.
REQ-016 alu_op_o  out  4  0 ADD, 1 SUB, 2 IN2_PASSTHROUGH, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA.
REQ-017 alu_in1_sel_o  out  1  0 = regfile out1, 1 = PC.
REQ-018 alu_in2_sel_o  out  2  0 = regfile out2, 1 = I-imm, 2 = U-imm, 3 = S/B/J-imm per opcode.
REQ-019 halted_o  out  1  control is in HALT.
REQ-020 fault_cause_o  out  2  0 none, 1 illegal instruction, 2 bus timeout; held while halted.

Function
REQ-021 States SHALL be RESET, FETCH, EXEC, MEM, HALT; selects not listed for a state SHALL be driven 0.
REQ-022 RESET SHALL go to FETCH on the first cycle reset_i is low; all enables 0.
REQ-023 FETCH SHALL drive mem_req_o=1, mem_we_o=0, mem_addr_sel_o=0; ir_we_o SHALL equal mem_ready_i; on mem_ready_i go EXEC.
REQ-024 EXEC SHALL decode ir_i: LUI (IN2_PASSTHROUGH, U-imm), AUIPC (ADD, PC, U-imm), OP_IMM and OP (all RV32I funct3; funct7[5] selects SUB/SRA), JAL/JALR (regfile_in_sel=2, next_pc_sel=1), writing rd with regfile_we_o=1 and pc_we_o=1, then FETCH.
REQ-025 BRANCH in EXEC SHALL drive pc_we_o=1, regfile_we_o=0, next_pc_sel_o = branch_taken_i ? 1 : 0, then FETCH.
REQ-026 LOAD/STORE in EXEC SHALL drive alu ADD with regfile out1 and offset, pc_we_o=0, then MEM.
REQ-027 MEM SHALL drive mem_req_o=1, mem_addr_sel_o=1, mem_we_o=1 for store; on mem_ready_i pc_we_o=1, load additionally regfile_we_o=1 with regfile_in_sel_o=1, then FETCH.
REQ-028 mem_req_o, mem_we_o and mem_addr_sel_o SHALL stay stable from assertion until the cycle mem_ready_i is sampled high.
REQ-029 A wait counter SHALL clear on entry to FETCH/MEM and increment each cycle without mem_ready_i; reaching TIMEOUT_CYCLES-1 with mem_ready_i low SHALL go HALT, cause 2.
REQ-030 mem_ready_i high in the terminal-count cycle SHALL complete normally (ready wins over timeout).
REQ-031 Unknown opcode/funct3/funct7 or disabled store in EXEC SHALL go HALT, cause 1, with no write enable asserted.
REQ-032 HALT SHALL assert halted_o, deassert all enables and mem_req_o, and remain until reset.
REQ-033 mem_ready_i outside FETCH/MEM SHALL be ignored.

Reset
REQ-034 reset_i high in any state, including mid-access, SHALL next cycle enter RESET, clear counter and fault_cause_o, and drive all enables, mem_req_o and halted_o 0.

Verification
REQ-035 ADDI x1,x0,5 with mem_ready_i always high -> FETCH,EXEC,FETCH; EXEC has regfile_we_o=1, alu_op_o=0, alu_in2_sel_o=1, pc_we_o=1.
REQ-036 LW with ready delayed 3 cycles in MEM -> mem_req_o held 4 cycles, address selection stable, regfile_we_o=1 and regfile_in_sel_o=1 only in ready cycle.
REQ-037 BEQ with branch_taken_i=1 then 0 -> next_pc_sel_o=1 then 0, regfile_we_o=0 both.
REQ-038 TIMEOUT_CYCLES=4, mem_ready_i low in FETCH -> HALT after 4 FETCH cycles, fault_cause_o=2; ready in 4th cycle instead -> EXEC.
REQ-039 ir_i=0x00000000 or ENABLE_STORE=0 with SW -> HALT, fault_cause_o=1, no enables.
REQ-040 reset_i pulsed during MEM wait -> RESET next cycle, mem_req_o=0, then FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV32I core: sequences fetch, execute and memory
// phases, and halts on an illegal instruction or a memory wait timeout.
module multicycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          ENABLE_STORE   = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] ir_i,
  input  logic        mem_ready_i,
  input  logic        branch_taken_i,
  output logic        pc_we_o,
  output logic        ir_we_o,
  output logic        regfile_we_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic [1:0]  next_pc_sel_o,
  output logic [1:0]  regfile_in_sel_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_in1_sel_o,
  output logic [1:0]  alu_in2_sel_o,
  output logic        halted_o,
  output logic [1:0]  fault_cause_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluPass = 4'd2;
  localparam logic [3:0] AluAnd  = 4'd3;
  localparam logic [3:0] AluOr   = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSlt  = 4'd6;
  localparam logic [3:0] AluSltu = 4'd7;
  localparam logic [3:0] AluSll  = 4'd8;
  localparam logic [3:0] AluSrl  = 4'd9;
  localparam logic [3:0] AluSra  = 4'd10;

  typedef enum logic [2:0] {StReset, StFetch, StExec, StMem, StHalt} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      cause_q, cause_d;
  logic            illegal;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_store;
  logic       unused_ir;

  assign opcode    = ir_i[6:0];
  assign funct3    = ir_i[14:12];
  assign funct7    = ir_i[31:25];
  assign is_store  = (opcode == OpStore);
  assign unused_ir = ^{ir_i[24:15], ir_i[11:7]};

  // alt selects SUB for funct3 000 and SRA for funct3 101.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StReset;
      cnt_q   <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = '0;
    cause_d          = cause_q;
    illegal          = 1'b0;
    pc_we_o          = 1'b0;
    ir_we_o          = 1'b0;
    regfile_we_o     = 1'b0;
    mem_req_o        = 1'b0;
    mem_we_o         = 1'b0;
    mem_addr_sel_o   = 1'b0;
    next_pc_sel_o    = 2'd0;
    regfile_in_sel_o = 2'd0;
    alu_op_o         = AluAdd;
    alu_in1_sel_o    = 1'b0;
    alu_in2_sel_o    = 2'd0;
    halted_o         = 1'b0;

    unique case (state_q)
      StReset: state_d = StFetch;

      StFetch: begin
        mem_req_o = 1'b1;
        ir_we_o   = mem_ready_i;
        if (mem_ready_i) begin
          state_d = StExec;
        end else if (cnt_q == TermCnt) begin
          state_d = StHalt;
          cause_d = 2'd2;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StExec: begin
        state_d = StFetch;
        case (opcode)
          OpLui: begin
            alu_op_o      = AluPass;
            alu_in2_sel_o = 2'd2;
            regfile_we_o  = 1'b1;
            pc_we_o       = 1'b1;
          end
          OpAuipc: begin
            alu_in1_sel_o = 1'b1;
            alu_in2_sel_o = 2'd2;
            regfile_we_o  = 1'b1;
            pc_we_o       = 1'b1;
          end
          OpImm: begin
            alu_op_o      = alu_of(funct3, funct7[5] && (funct3 == 3'b101));
            alu_in2_sel_o = 2'd1;
            regfile_we_o  = 1'b1;
            pc_we_o       = 1'b1;
            if (funct3 == 3'b001) illegal = (funct7 != 7'h00);
            if (funct3 == 3'b101) illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
          end
          OpReg: begin
            alu_op_o     = alu_of(funct3, funct7[5]);
            regfile_we_o = 1'b1;
            pc_we_o      = 1'b1;
            illegal      = !((funct7 == 7'h00) ||
                             ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
          end
          OpJal: begin
            alu_in1_sel_o    = 1'b1;
            alu_in2_sel_o    = 2'd3;
            regfile_in_sel_o = 2'd2;
            next_pc_sel_o    = 2'd1;
            regfile_we_o     = 1'b1;
            pc_we_o          = 1'b1;
          end
          OpJalr: begin
            alu_in2_sel_o    = 2'd1;
            regfile_in_sel_o = 2'd2;
            next_pc_sel_o    = 2'd1;
            regfile_we_o     = 1'b1;
            pc_we_o          = 1'b1;
            illegal          = (funct3 != 3'b000);
          end
          OpBranch: begin
            alu_in1_sel_o = 1'b1;
            alu_in2_sel_o = 2'd3;
            next_pc_sel_o = {1'b0, branch_taken_i};
            pc_we_o       = 1'b1;
            illegal       = (funct3[2:1] == 2'b01);
          end
          OpLoad: begin
            alu_in2_sel_o = 2'd1;
            state_d       = StMem;
            illegal       = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
          end
          OpStore: begin
            alu_in2_sel_o = 2'd3;
            state_d       = StMem;
            illegal       = !ENABLE_STORE || funct3[2] || (funct3 == 3'b011);
          end
          default: illegal = 1'b1;
        endcase
        if (illegal) begin
          pc_we_o          = 1'b0;
          regfile_we_o     = 1'b0;
          next_pc_sel_o    = 2'd0;
          regfile_in_sel_o = 2'd0;
          alu_op_o         = AluAdd;
          alu_in1_sel_o    = 1'b0;
          alu_in2_sel_o    = 2'd0;
          state_d          = StHalt;
          cause_d          = 2'd1;
        end
      end

      StMem: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = is_store;
        // Keep the ALU computing base+offset so the address stays valid.
        alu_in2_sel_o  = is_store ? 2'd3 : 2'd1;
        if (mem_ready_i) begin
          pc_we_o = 1'b1;
          if (!is_store) begin
            regfile_we_o     = 1'b1;
            regfile_in_sel_o = 2'd1;
          end
          state_d = StFetch;
        end else if (cnt_q == TermCnt) begin
          state_d = StHalt;
          cause_d = 2'd2;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StHalt: halted_o = 1'b1;

      default: state_d = StReset;
    endcase
  end

  assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against an
// instruction-level reference model of the control sequence.
module tb_multicycle_control;

  localparam int unsigned TO = 4;
  localparam logic [31:0] AddiX1 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] LwX2   = 32'h0000_A103;  // lw   x2,0(x1)
  localparam logic [31:0] SwX2   = 32'h0020_A023;  // sw   x2,0(x1)
  localparam logic [31:0] BeqX0  = 32'h0000_0063;  // beq  x0,x0,0

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       rf_we;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic [1:0] npc;
    logic [1:0] rf_in;
    logic [3:0] alu;
    logic       in1;
    logic [1:0] in2;
    logic       halted;
    logic [1:0] cause;
  } ctl_t;

  // ALU op for each funct3 with funct7[5] clear: ADD SLL SLT SLTU XOR SRL OR AND.
  localparam logic [3:0] AluOfF3 [8] = '{4'd0, 4'd8, 4'd6, 4'd7, 4'd5, 4'd9, 4'd4, 4'd3};
  localparam logic [6:0] Opcodes [9] = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h6f, 7'h67, 7'h63,
                                         7'h03, 7'h23};

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] ir_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        branch_taken_i = 1'b0;

  logic       pc_we_m, ir_we_m, rf_we_m, mem_req_m, mem_we_m, addr_sel_m, in1_m, halted_m;
  logic [1:0] npc_m, rf_in_m, in2_m, cause_m;
  logic [3:0] alu_m;
  logic       pc_we_n, ir_we_n, rf_we_n, mem_req_n, mem_we_n, addr_sel_n, in1_n, halted_n;
  logic [1:0] npc_n, rf_in_n, in2_n, cause_n;
  logic [3:0] alu_n;

  ctl_t act_m, act_n, mask_no_alu;
  int   n_checks = 0;
  int   n_fail = 0;

  assign act_m = {pc_we_m, ir_we_m, rf_we_m, mem_req_m, mem_we_m, addr_sel_m, npc_m, rf_in_m,
                  alu_m, in1_m, in2_m, halted_m, cause_m};
  assign act_n = {pc_we_n, ir_we_n, rf_we_n, mem_req_n, mem_we_n, addr_sel_n, npc_n, rf_in_n,
                  alu_n, in1_n, in2_n, halted_n, cause_n};

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT_CYCLES(TO), .ENABLE_STORE(1'b1)) u_dut (
    .clk_i(clk), .reset_i(reset_i), .ir_i(ir_i), .mem_ready_i(mem_ready_i),
    .branch_taken_i(branch_taken_i), .pc_we_o(pc_we_m), .ir_we_o(ir_we_m),
    .regfile_we_o(rf_we_m), .mem_req_o(mem_req_m), .mem_we_o(mem_we_m),
    .mem_addr_sel_o(addr_sel_m), .next_pc_sel_o(npc_m), .regfile_in_sel_o(rf_in_m),
    .alu_op_o(alu_m), .alu_in1_sel_o(in1_m), .alu_in2_sel_o(in2_m), .halted_o(halted_m),
    .fault_cause_o(cause_m)
  );

  multicycle_control #(.ENABLE_STORE(1'b0)) u_dut_ns (
    .clk_i(clk), .reset_i(reset_i), .ir_i(ir_i), .mem_ready_i(mem_ready_i),
    .branch_taken_i(branch_taken_i), .pc_we_o(pc_we_n), .ir_we_o(ir_we_n),
    .regfile_we_o(rf_we_n), .mem_req_o(mem_req_n), .mem_we_o(mem_we_n),
    .mem_addr_sel_o(addr_sel_n), .next_pc_sel_o(npc_n), .regfile_in_sel_o(rf_in_n),
    .alu_op_o(alu_n), .alu_in1_sel_o(in1_n), .alu_in2_sel_o(in2_n), .halted_o(halted_n),
    .fault_cause_o(cause_n)
  );

  // Expected EXEC-cycle controls; nxt: 0 back to fetch, 1 memory phase, 2 illegal halt.
  function automatic void model_exec(input logic [31:0] ir, input logic tk, input bit store_en,
                                     output ctl_t e, output int nxt);
    logic [6:0] opc = ir[6:0];
    logic [2:0] f3 = ir[14:12];
    logic [6:0] f7 = ir[31:25];
    bit legal = 1'b1;
    bit wr = 1'b0;
    e = '0;
    nxt = 0;
    if (opc == 7'h37) begin
      e.alu = 4'd2; e.in2 = 2'd2; wr = 1'b1;
    end else if (opc == 7'h17) begin
      e.in1 = 1'b1; e.in2 = 2'd2; wr = 1'b1;
    end else if (opc == 7'h13) begin
      e.in2 = 2'd1; wr = 1'b1; e.alu = AluOfF3[f3];
      if (f3 == 3'd1) legal = (f7 == 7'h00);
      if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      if (f3 == 3'd5 && f7 == 7'h20) e.alu = 4'd10;
    end else if (opc == 7'h33) begin
      wr = 1'b1; e.alu = AluOfF3[f3];
      if (f7 == 7'h20) begin
        legal = (f3 == 3'd0) || (f3 == 3'd5);
        e.alu = (f3 == 3'd0) ? 4'd1 : 4'd10;
      end else begin
        legal = (f7 == 7'h00);
      end
    end else if (opc == 7'h6f) begin
      wr = 1'b1; e.rf_in = 2'd2; e.npc = 2'd1; e.in1 = 1'b1; e.in2 = 2'd3;
    end else if (opc == 7'h67) begin
      wr = 1'b1; e.rf_in = 2'd2; e.npc = 2'd1; e.in2 = 2'd1; legal = (f3 == 3'd0);
    end else if (opc == 7'h63) begin
      e.pc_we = 1'b1; e.npc = tk ? 2'd1 : 2'd0; legal = (f3 != 3'd2) && (f3 != 3'd3);
    end else if (opc == 7'h03) begin
      e.in2 = 2'd1; nxt = 1;
      legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    end else if (opc == 7'h23) begin
      e.in2 = 2'd3; nxt = 1; legal = store_en && (f3 <= 3'd2);
    end else begin
      legal = 1'b0;
    end
    if (wr) begin
      e.rf_we = 1'b1;
      e.pc_we = 1'b1;
    end
    if (!legal) begin
      e = '0;
      nxt = 2;
    end
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r = $urandom;
    int k = int'($urandom_range(0, 11));
    int sel = int'($urandom_range(0, 3));
    if (k < 9) r[6:0] = Opcodes[k];
    if (r[6:0] == 7'h13 || r[6:0] == 7'h33) begin
      if (sel == 0 || sel == 3) r[31:25] = 7'h00;
      else if (sel == 1) r[31:25] = 7'h20;
    end
    return r;
  endfunction

  task automatic drive(input logic rdy, input logic tk);
    @(negedge clk);
    mem_ready_i = rdy;
    branch_taken_i = tk;
    #1;
  endtask

  // Leaves the DUTs in RESET with reset_i low; the next drive() lands in FETCH.
  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    mem_ready_i = 1'($urandom);
    @(negedge clk);
    reset_i = 1'b0;
    mem_ready_i = 1'($urandom);
    #1;
    n_checks++;
    if (act_m !== ctl_t'(0)) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", act_m, ctl_t'(0));
    end
    n_checks++;
    if (act_n !== ctl_t'(0)) begin
      n_fail++; $display("FAIL reset_state_ns: got %h want %h", act_n, ctl_t'(0));
    end
  endtask

  task automatic do_fetch(input int d, output bit ok);
    ctl_t e;
    ok = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      drive(i == d, 1'($urandom));
      e = '0; e.mem_req = 1'b1; e.ir_we = (i == d);
      n_checks++;
      if (act_m !== e) begin
        n_fail++; $display("FAIL fetch[%0d]: got %h want %h", i, act_m, e);
      end
      if (i == d) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      drive(1'($urandom), 1'($urandom));
      e = '0; e.halted = 1'b1; e.cause = 2'd2;
      n_checks++;
      if (act_m !== e) begin
        n_fail++; $display("FAIL fetch_timeout_halt: got %h want %h", act_m, e);
      end
    end
  endtask

  task automatic do_exec(input logic [31:0] ir, input logic tk, output int nxt);
    ctl_t e, m;
    ir_i = ir;
    drive(1'($urandom), tk);
    model_exec(ir, tk, 1'b1, e, nxt);
    m = '1;
    if (ir[6:0] == 7'h63 && nxt == 0) m = mask_no_alu;
    n_checks++;
    if ((act_m & m) !== (e & m)) begin
      n_fail++; $display("FAIL exec ir=%h: got %h want %h", ir, act_m & m, e & m);
    end
    if (nxt == 2) begin
      drive(1'($urandom), 1'($urandom));
      e = '0; e.halted = 1'b1; e.cause = 2'd1;
      n_checks++;
      if (act_m !== e) begin
        n_fail++; $display("FAIL illegal_halt ir=%h: got %h want %h", ir, act_m, e);
      end
    end
  endtask

  task automatic do_mem(input int d, input bit store, output bit ok);
    ctl_t e;
    ok = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      drive(i == d, 1'($urandom));
      e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = store;
      if (i == d) begin
        e.pc_we = 1'b1;
        if (!store) begin
          e.rf_we = 1'b1; e.rf_in = 2'd1;
        end
      end
      n_checks++;
      if ((act_m & mask_no_alu) !== (e & mask_no_alu)) begin
        n_fail++; $display("FAIL mem[%0d]: got %h want %h", i, act_m & mask_no_alu, e);
      end
      if (i == d) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      drive(1'($urandom), 1'($urandom));
      e = '0; e.halted = 1'b1; e.cause = 2'd2;
      n_checks++;
      if (act_m !== e) begin
        n_fail++; $display("FAIL mem_timeout_halt: got %h want %h", act_m, e);
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    do_fetch(2, ok);
  endtask

  task automatic test_addi();
    bit ok;
    int nxt;
    do_reset();
    do_fetch(0, ok);
    do_exec(AddiX1, 1'b0, nxt);
    do_fetch(0, ok);
  endtask

  task automatic test_load_wait();
    bit ok;
    int nxt;
    do_reset();
    do_fetch(0, ok);
    do_exec(LwX2, 1'b1, nxt);
    do_mem(3, 1'b0, ok);
    do_fetch(0, ok);
  endtask

  task automatic test_branch();
    bit ok;
    int nxt;
    do_reset();
    do_fetch(0, ok);
    do_exec(BeqX0, 1'b1, nxt);
    do_fetch(1, ok);
    do_exec(BeqX0, 1'b0, nxt);
    do_fetch(0, ok);
  endtask

  task automatic test_timeout();
    ctl_t e;
    bit ok;
    int nxt;
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      drive(1'b0, 1'($urandom));
      e = '0;
      if (i < int'(TO)) e.mem_req = 1'b1;
      else begin e.halted = 1'b1; e.cause = 2'd2; end
      n_checks++;
      if (act_m !== e) begin
        n_fail++; $display("FAIL timeout_short[%0d]: got %h want %h", i, act_m, e);
      end
      e = '0;
      if (i < 16) e.mem_req = 1'b1;
      else begin e.halted = 1'b1; e.cause = 2'd2; end
      n_checks++;
      if (act_n !== e) begin
        n_fail++; $display("FAIL timeout_default[%0d]: got %h want %h", i, act_n, e);
      end
    end
    e = '0; e.halted = 1'b1; e.cause = 2'd2;
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 1'($urandom));
      n_checks++;
      if (act_m !== e) begin
        n_fail++; $display("FAIL halt_hold[%0d]: got %h want %h", i, act_m, e);
      end
    end
    do_reset();
    do_fetch(int'(TO) - 1, ok);
    do_exec(AddiX1, 1'b0, nxt);
  endtask

  task automatic test_illegal();
    ctl_t e;
    bit ok;
    int nxt;
    do_reset();
    do_fetch(0, ok);
    do_exec(32'h0000_0000, 1'b1, nxt);
    e = '0; e.halted = 1'b1; e.cause = 2'd1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom));
      n_checks++;
      if (act_m !== e) begin
        n_fail++; $display("FAIL illegal_hold[%0d]: got %h want %h", i, act_m, e);
      end
    end
  endtask

  task automatic test_store_disabled();
    ctl_t e;
    bit ok;
    int nxt, nxt_ns;
    do_reset();
    do_fetch(1, ok);
    do_exec(SwX2, 1'b0, nxt);
    model_exec(SwX2, 1'b0, 1'b0, e, nxt_ns);
    n_checks++;
    if (act_n !== e) begin
      n_fail++; $display("FAIL store_disabled_exec: got %h want %h", act_n, e);
    end
    do_mem(0, 1'b1, ok);
    e = '0; e.halted = 1'b1; e.cause = 2'd1;
    n_checks++;
    if (act_n !== e) begin
      n_fail++; $display("FAIL store_disabled_halt: got %h want %h", act_n, e);
    end
  endtask

  task automatic test_reset_mid_mem();
    ctl_t e;
    bit ok;
    int nxt;
    do_reset();
    do_fetch(0, ok);
    do_exec(LwX2, 1'b0, nxt);
    e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1;
    drive(1'b0, 1'b0);
    n_checks++;
    if ((act_m & mask_no_alu) !== e) begin
      n_fail++; $display("FAIL mem_wait: got %h want %h", act_m & mask_no_alu, e);
    end
    @(negedge clk);
    reset_i = 1'b1;
    mem_ready_i = 1'b0;
    #1;
    n_checks++;
    if ((act_m & mask_no_alu) !== e) begin
      n_fail++; $display("FAIL mem_wait_rst: got %h want %h", act_m & mask_no_alu, e);
    end
    @(negedge clk);
    reset_i = 1'b0;
    mem_ready_i = 1'b1;
    #1;
    n_checks++;
    if (act_m !== ctl_t'(0)) begin
      n_fail++; $display("FAIL reset_mid_mem: got %h want %h", act_m, ctl_t'(0));
    end
    do_fetch(0, ok);
  endtask

  task automatic test_random();
    bit ok;
    int d, nxt;
    logic [31:0] ir;
    do_reset();
    for (int n = 0; n < 250; n++) begin
      d = ($urandom_range(0, 15) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
      do_fetch(d, ok);
      if (!ok) begin
        do_reset();
        continue;
      end
      ir = gen_instr();
      do_exec(ir, 1'($urandom), nxt);
      if (nxt == 2) begin
        do_reset();
      end else if (nxt == 1) begin
        d = ($urandom_range(0, 15) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
        do_mem(d, ir[6:0] == 7'h23, ok);
        if (!ok) do_reset();
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mask_no_alu = '1;
    mask_no_alu.alu = '0;
    mask_no_alu.in1 = 1'b0;
    mask_no_alu.in2 = '0;
    test_reset();
    test_addi();
    test_load_wait();
    test_branch();
    test_timeout();
    test_illegal();
    test_store_disabled();
    test_reset_mid_mem();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
